id_hazard_controller: RTL and testbench
=======================================

Name: id_hazard_controller

Overview:
- Control and sequencing block for the instruction-decode (ID) stage of the 5-stage pipelined CPU.
- Decodes the IF/ID instruction and selects the immediate-extension mode for the ID sign/zero extender.
- Detects load-use hazards and sequences stall and flush of PC, IF/ID and ID/EX.
- Produces the registered control fields of the ID/EX pipeline register.

Parameters:
STALL_CNT_W, 16, width of the saturating stall-cycle counter
REG_ADDR_W, 5, register-file address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_id_instr  input  32  instruction held in IF/ID
if_id_valid  input  1  IF/ID holds a real instruction
id_ex_mem_read  input  1  instruction now in EX is a load
id_ex_rt  input  REG_ADDR_W  destination rt of instruction now in EX
ex_branch_taken  input  1  branch resolved taken in EX this cycle
ext_mode  output  2  extender mode: 00 sign, 01 zero, 10 upper (imm<<16); combinational
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  clear IF/ID to NOP at next edge
ctl_reg_dst, ctl_alu_src, ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg, ctl_branch  output  1 each  registered ID/EX control fields
ctl_alu_op  output  2  registered: 00 add, 01 sub, 10 R-type funct, 11 immediate-logic
illegal_op  output  1  registered: unsupported opcode decoded
stall_count  output  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n=0, async): FSM=RUN; all ctl_*, ctl_alu_op and illegal_op = 0; stall_count=0.
  - Combinational outputs during reset: pc_write=1, if_id_write=1, if_id_flush=0.
  - Reset mid-stall aborts the stall immediately.
- Decode uses op=instr[31:26], rs=[25:21], rt=[20:16].
- Opcode table, with ext_mode / alu_op / controls:
  - 0x00 R-type: x / 10 / reg_dst, reg_write.
  - 0x23 lw: sign / 00 / alu_src, mem_read, reg_write, mem_to_reg.
  - 0x2B sw: sign / 00 / alu_src, mem_write.
  - 0x04 beq: sign / 01 / branch.
  - 0x08 addi: sign / 00 / alu_src, reg_write.
  - 0x0A slti: sign / 11 / alu_src, reg_write.
  - 0x0C andi: zero / 11 / alu_src, reg_write.
  - 0x0D ori: zero / 11 / alu_src, reg_write.
  - 0x0F lui: upper / 11 / alu_src, reg_write.
  - Any other opcode: all controls 0, illegal_op=1.
  - ext_mode defaults to 00 for R-type and illegal opcodes.
- Hazard = if_id_valid & id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==rs | (id_ex_rt==rt & op uses rt as source)).
  - rt is a source for R-type, sw and beq only.
- FSM states: RUN, STALL, FLUSH.
  - RUN → FLUSH if ex_branch_taken. Branch has priority over hazard in the same cycle.
  - RUN → STALL if hazard and no branch.
  - STALL → RUN unconditionally after exactly one cycle. The inserted bubble clears id_ex_mem_read.
    - If ex_branch_taken is seen in STALL, go to FLUSH instead.
  - FLUSH → RUN after one cycle.
- Outputs by cycle (combinational from current state and inputs):
  - The cycle the hazard is detected in RUN: pc_write=0, if_id_write=0; ID/EX is loaded with a bubble at the edge.
  - The cycle ex_branch_taken is seen: if_id_flush=1; ID/EX is loaded with a bubble at the edge. pc_write stays 1 so the branch target loads.
  - In STALL and FLUSH: pc_write=1, if_id_write=1, if_id_flush=0, unless a new branch arrives.
- Registered controls (1-cycle latency):
  - At each edge, ctl_* and illegal_op take the decoded values.
  - They take all zeros if if_id_valid=0, a bubble is inserted, or a flush is issued.
- stall_count increments once per edge at which a load-use bubble is inserted. It saturates at all-ones with no wrap.

Decomposition:
- Shared package/header `cpu_defs`:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI.
  - EXT_SIGN, EXT_ZERO, EXT_UPPER.
  - ALU_OP_* encodings.
  - FSM state encodings.
- One natural sub-module: `id_main_decoder`, purely combinational (opcode → control vector, ext_mode, illegal). The FSM, hazard compare and control register stay in the top.

Test Plan:
1. Reset then release; IF/ID = andi (0x3109FFFF) valid → ext_mode=01 immediately; next edge ctl_alu_src=1, ctl_reg_write=1, ctl_alu_op=11.
2. id_ex_mem_read=1, id_ex_rt=8; IF/ID = add with rs=8 (0x01095020):
   - same cycle: pc_write=0, if_id_write=0;
   - next edge: all ctl_*=0, stall_count=1, state STALL;
   - following cycle: pc_write=1.
3. Same as 2 but id_ex_rt=0 → no stall, stall_count stays 0. Also with IF/ID = addi where rt=8 is the destination → no stall.
4. Hazard and ex_branch_taken=1 in the same cycle → if_id_flush=1, pc_write=1, no stall, stall_count unchanged; next edge ctl_*=0, state FLUSH.
5. IF/ID opcode 0x3F valid → next edge illegal_op=1, all ctl_*=0. IF/ID = lui 0x3C01ABCD → ext_mode=10.
6. Drop rst_n asynchronously while in STALL → outputs clear before the next clk edge. Also force stall_count to all-ones via repeated hazards with STALL_CNT_W=2 → it holds at 3.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode, extender, ALU-op, FSM and control-vector definitions
package cpu_defs;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // Immediate extender modes
  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // ALU operation class handed to the EX-stage ALU control
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  // Hazard sequencer states
  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  // Control fields carried into the ID/EX register
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } id_ex_ctl_t;

endpackage

// File: rtl/id_main_decoder.sv
// rtl/id_main_decoder.sv - combinational opcode to control-vector decoder
module id_main_decoder
  import cpu_defs::*;
(
  input  logic [5:0]  opcode,
  output id_ex_ctl_t  ctl,
  output logic [1:0]  ext_mode,
  output logic        rt_is_src
);

  // Opcode table; anything not listed is flagged illegal with all controls low
  always_comb begin
    ctl       = '0;
    ext_mode  = EXT_SIGN;
    rt_is_src = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ALU_OP_FUNCT;
        rt_is_src     = 1'b1;
      end
      OP_LW: begin
        ctl.alu_src    = 1'b1;
        ctl.mem_read   = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        ctl.alu_src   = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.alu_op    = ALU_OP_ADD;
        rt_is_src     = 1'b1;
      end
      OP_BEQ: begin
        ctl.branch = 1'b1;
        ctl.alu_op = ALU_OP_SUB;
        rt_is_src  = 1'b1;
      end
      OP_ADDI: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ALU_OP_ADD;
      end
      OP_SLTI: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ALU_OP_IMM;
      end
      OP_ANDI, OP_ORI: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ALU_OP_IMM;
        ext_mode      = EXT_ZERO;
      end
      OP_LUI: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ALU_OP_IMM;
        ext_mode      = EXT_UPPER;
      end
      default: begin
        ctl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_hazard_controller.sv
// rtl/id_hazard_controller.sv - ID-stage decode, load-use stall and branch flush sequencing
module id_hazard_controller #(
  parameter int STALL_CNT_W = 16,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            if_id_instr,
  input  logic                   if_id_valid,
  input  logic                   id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  id_ex_rt,
  input  logic                   ex_branch_taken,
  output logic [1:0]             ext_mode,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   ctl_reg_dst,
  output logic                   ctl_alu_src,
  output logic                   ctl_mem_read,
  output logic                   ctl_mem_write,
  output logic                   ctl_reg_write,
  output logic                   ctl_mem_to_reg,
  output logic                   ctl_branch,
  output logic [1:0]             ctl_alu_op,
  output logic                   illegal_op,
  output logic [STALL_CNT_W-1:0] stall_count
);
  import cpu_defs::*;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic                  unused_imm;
  id_ex_ctl_t            dec_ctl;
  id_ex_ctl_t            ctl_q;
  logic                  rt_is_src;
  logic                  hazard;
  logic                  stall_bubble;
  logic                  bubble;
  logic [1:0]            state;
  logic [1:0]            state_nxt;

  assign opcode     = if_id_instr[31:26];
  assign rs         = if_id_instr[21 +: REG_ADDR_W];
  assign rt         = if_id_instr[16 +: REG_ADDR_W];
  assign unused_imm = ^if_id_instr[15:0];

  id_main_decoder u_dec (
    .opcode    (opcode),
    .ctl       (dec_ctl),
    .ext_mode  (ext_mode),
    .rt_is_src (rt_is_src)
  );

  // $0 is never a real producer, so a load targeting it cannot create a dependency
  assign hazard = if_id_valid & id_ex_mem_read & (id_ex_rt != '0) &
                  ((id_ex_rt == rs) | ((id_ex_rt == rt) & rt_is_src));

  // Stall/flush sequencing; a taken branch overrides any hazard, reset forces free-running fetch
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    stall_bubble = 1'b0;
    state_nxt    = ST_RUN;
    if (rst_n) begin
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        state_nxt   = ST_FLUSH;
      end else begin
        case (state)
          ST_RUN: begin
            if (hazard) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              stall_bubble = 1'b1;
              state_nxt    = ST_STALL;
            end
          end
          ST_STALL: state_nxt = ST_RUN;
          ST_FLUSH: state_nxt = ST_RUN;
          default:  state_nxt = ST_RUN;
        endcase
      end
    end
  end

  assign bubble = stall_bubble | if_id_flush | ~if_id_valid;

  // FSM state, ID/EX control register and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      ctl_q       <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      ctl_q <= bubble ? '0 : dec_ctl;
      if (stall_bubble && (stall_count != '1)) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

  assign ctl_reg_dst    = ctl_q.reg_dst;
  assign ctl_alu_src    = ctl_q.alu_src;
  assign ctl_mem_read   = ctl_q.mem_read;
  assign ctl_mem_write  = ctl_q.mem_write;
  assign ctl_reg_write  = ctl_q.reg_write;
  assign ctl_mem_to_reg = ctl_q.mem_to_reg;
  assign ctl_branch     = ctl_q.branch;
  assign ctl_alu_op     = ctl_q.alu_op;
  assign illegal_op     = ctl_q.illegal;

endmodule

// File: tb/tb_id_hazard_controller.sv
// tb/tb_id_hazard_controller.sv - directed self-checking bench for id_hazard_controller
module tb_id_hazard_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic        ex_branch_taken;

  logic [1:0]  ext_mode;
  logic        pc_write, if_id_write, if_id_flush;
  logic        ctl_reg_dst, ctl_alu_src, ctl_mem_read, ctl_mem_write;
  logic        ctl_reg_write, ctl_mem_to_reg, ctl_branch;
  logic [1:0]  ctl_alu_op;
  logic        illegal_op;
  logic [15:0] stall_count;

  logic [1:0]  s_ext_mode;
  logic        s_pc_write, s_if_id_write, s_if_id_flush;
  logic        s_reg_dst, s_alu_src, s_mem_read, s_mem_write;
  logic        s_reg_write, s_mem_to_reg, s_branch;
  logic [1:0]  s_alu_op;
  logic        s_illegal_op;
  logic [1:0]  s_stall_count;

  logic [9:0]  ctl_vec;

  int n_checks;
  int n_fail;

  // {reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, alu_op[1:0], illegal}
  localparam logic [9:0] V_ZERO  = 10'b0000000000;
  localparam logic [9:0] V_RTYPE = 10'b1000100100;
  localparam logic [9:0] V_ANDI  = 10'b0100100110;
  localparam logic [9:0] V_ADDI  = 10'b0100100000;
  localparam logic [9:0] V_SW    = 10'b0101000000;
  localparam logic [9:0] V_LW    = 10'b0110110000;
  localparam logic [9:0] V_BEQ   = 10'b0000001010;
  localparam logic [9:0] V_ILL   = 10'b0000000001;

  localparam logic [31:0] I_ANDI   = 32'h3109FFFF;
  localparam logic [31:0] I_ADD    = 32'h01095020;
  localparam logic [31:0] I_ADD_R0 = 32'h00095020;
  localparam logic [31:0] I_ADDI   = 32'h20080005;
  localparam logic [31:0] I_SW     = 32'hAD280000;
  localparam logic [31:0] I_LW     = 32'h8D090004;
  localparam logic [31:0] I_BEQ    = 32'h11090003;
  localparam logic [31:0] I_LUI    = 32'h3C01ABCD;
  localparam logic [31:0] I_ILL    = 32'hFC000000;

  assign ctl_vec = {ctl_reg_dst, ctl_alu_src, ctl_mem_read, ctl_mem_write, ctl_reg_write,
                    ctl_mem_to_reg, ctl_branch, ctl_alu_op, illegal_op};

  id_hazard_controller #(.STALL_CNT_W(16), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .ex_branch_taken(ex_branch_taken),
    .ext_mode(ext_mode), .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .ctl_reg_dst(ctl_reg_dst), .ctl_alu_src(ctl_alu_src), .ctl_mem_read(ctl_mem_read),
    .ctl_mem_write(ctl_mem_write), .ctl_reg_write(ctl_reg_write), .ctl_mem_to_reg(ctl_mem_to_reg),
    .ctl_branch(ctl_branch), .ctl_alu_op(ctl_alu_op), .illegal_op(illegal_op),
    .stall_count(stall_count)
  );

  id_hazard_controller #(.STALL_CNT_W(2), .REG_ADDR_W(5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .ex_branch_taken(ex_branch_taken),
    .ext_mode(s_ext_mode), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .ctl_reg_dst(s_reg_dst), .ctl_alu_src(s_alu_src),
    .ctl_mem_read(s_mem_read), .ctl_mem_write(s_mem_write), .ctl_reg_write(s_reg_write),
    .ctl_mem_to_reg(s_mem_to_reg), .ctl_branch(s_branch), .ctl_alu_op(s_alu_op),
    .illegal_op(s_illegal_op), .stall_count(s_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] instr, input logic valid, input logic mr,
                        input logic [4:0] rt, input logic br);
    if_id_instr     = instr;
    if_id_valid     = valid;
    id_ex_mem_read  = mr;
    id_ex_rt        = rt;
    ex_branch_taken = br;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in(I_ADD, 1'b1, 1'b1, 5'd8, 1'b1);
    tick();
    tick();
    n_checks++; if (ctl_vec !== V_ZERO) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl_vec, V_ZERO); end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", stall_count); end
    n_checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin n_fail++; $display("FAIL reset_write got=%b%b exp=11", pc_write, if_id_write); end
    n_checks++; if (if_id_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", if_id_flush); end
    set_in(32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode_andi;
    set_in(I_ANDI, 1'b1, 1'b0, 5'd0, 1'b0);
    n_checks++; if (ext_mode !== 2'b01) begin n_fail++; $display("FAIL andi_ext got=%b exp=01", ext_mode); end
    tick();
    n_checks++; if (ctl_vec !== V_ANDI) begin n_fail++; $display("FAIL andi_ctl got=%b exp=%b", ctl_vec, V_ANDI); end
  endtask

  task automatic test_load_use_stall;
    set_in(I_ADD, 1'b1, 1'b1, 5'd8, 1'b0);
    n_checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin n_fail++; $display("FAIL stall_hold got=%b%b exp=00", pc_write, if_id_write); end
    n_checks++; if (if_id_flush !== 1'b0) begin n_fail++; $display("FAIL stall_flush got=%b exp=0", if_id_flush); end
    tick();
    n_checks++; if (ctl_vec !== V_ZERO) begin n_fail++; $display("FAIL stall_bubble got=%b exp=%b", ctl_vec, V_ZERO); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL stall_cnt1 got=%0d exp=1", stall_count); end
    // hazard inputs still present: only the STALL state releases pc_write here
    n_checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b%b exp=11", pc_write, if_id_write); end
    tick();
    n_checks++; if (ctl_vec !== V_RTYPE) begin n_fail++; $display("FAIL stall_proceed got=%b exp=%b", ctl_vec, V_RTYPE); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL stall_cnt_hold got=%0d exp=1", stall_count); end
    set_in(I_ADD, 1'b1, 1'b0, 5'd8, 1'b0);
    tick();
  endtask

  task automatic test_no_hazard;
    set_in(I_ADD_R0, 1'b1, 1'b1, 5'd0, 1'b0);
    n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL rt0_pc got=%b exp=1", pc_write); end
    tick();
    n_checks++; if (ctl_vec !== V_RTYPE || stall_count !== 16'd1) begin n_fail++; $display("FAIL rt0_ctl got=%b/%0d exp=%b/1", ctl_vec, stall_count, V_RTYPE); end
    set_in(I_ADDI, 1'b1, 1'b1, 5'd8, 1'b0);
    n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL addi_dst_pc got=%b exp=1", pc_write); end
    tick();
    n_checks++; if (ctl_vec !== V_ADDI || stall_count !== 16'd1) begin n_fail++; $display("FAIL addi_ctl got=%b/%0d exp=%b/1", ctl_vec, stall_count, V_ADDI); end
    set_in(I_ADD, 1'b0, 1'b1, 5'd8, 1'b0);
    n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL invalid_pc got=%b exp=1", pc_write); end
    tick();
    n_checks++; if (ctl_vec !== V_ZERO) begin n_fail++; $display("FAIL invalid_ctl got=%b exp=%b", ctl_vec, V_ZERO); end
  endtask

  task automatic test_sw_rt_hazard;
    set_in(I_SW, 1'b1, 1'b1, 5'd8, 1'b0);
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL sw_rt_pc got=%b exp=0", pc_write); end
    tick();
    n_checks++; if (stall_count !== 16'd2 || ctl_vec !== V_ZERO) begin n_fail++; $display("FAIL sw_rt_cnt got=%0d/%b exp=2/%b", stall_count, ctl_vec, V_ZERO); end
    set_in(I_SW, 1'b1, 1'b0, 5'd8, 1'b0);
    tick();
    n_checks++; if (ctl_vec !== V_SW) begin n_fail++; $display("FAIL sw_ctl got=%b exp=%b", ctl_vec, V_SW); end
  endtask

  task automatic test_branch_priority;
    set_in(I_ADD, 1'b1, 1'b1, 5'd8, 1'b1);
    n_checks++; if (if_id_flush !== 1'b1 || pc_write !== 1'b1) begin n_fail++; $display("FAIL br_prio got=flush%b pc%b exp=flush1 pc1", if_id_flush, pc_write); end
    tick();
    n_checks++; if (ctl_vec !== V_ZERO || stall_count !== 16'd2) begin n_fail++; $display("FAIL br_bubble got=%b/%0d exp=%b/2", ctl_vec, stall_count, V_ZERO); end
    set_in(I_ADD, 1'b1, 1'b1, 5'd8, 1'b0);
    n_checks++; if (pc_write !== 1'b1 || if_id_flush !== 1'b0) begin n_fail++; $display("FAIL flush_state got=pc%b flush%b exp=pc1 flush0", pc_write, if_id_flush); end
    tick();
    n_checks++; if (ctl_vec !== V_RTYPE || stall_count !== 16'd2) begin n_fail++; $display("FAIL flush_exit got=%b/%0d exp=%b/2", ctl_vec, stall_count, V_RTYPE); end
    // back in RUN with the hazard still present: a stall starts, then a branch arrives in STALL
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rerun_stall got=%b exp=0", pc_write); end
    tick();
    set_in(I_ADD, 1'b1, 1'b1, 5'd8, 1'b1);
    n_checks++; if (if_id_flush !== 1'b1 || pc_write !== 1'b1) begin n_fail++; $display("FAIL stall_br got=flush%b pc%b exp=flush1 pc1", if_id_flush, pc_write); end
    tick();
    n_checks++; if (ctl_vec !== V_ZERO || stall_count !== 16'd3) begin n_fail++; $display("FAIL stall_br_ctl got=%b/%0d exp=%b/3", ctl_vec, stall_count, V_ZERO); end
    set_in(32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_illegal_and_ext;
    set_in(I_ILL, 1'b1, 1'b0, 5'd0, 1'b0);
    n_checks++; if (ext_mode !== 2'b00) begin n_fail++; $display("FAIL ill_ext got=%b exp=00", ext_mode); end
    tick();
    n_checks++; if (ctl_vec !== V_ILL) begin n_fail++; $display("FAIL ill_ctl got=%b exp=%b", ctl_vec, V_ILL); end
    set_in(I_LUI, 1'b1, 1'b0, 5'd0, 1'b0);
    n_checks++; if (ext_mode !== 2'b10) begin n_fail++; $display("FAIL lui_ext got=%b exp=10", ext_mode); end
    set_in(I_LW, 1'b1, 1'b0, 5'd0, 1'b0);
    n_checks++; if (ext_mode !== 2'b00) begin n_fail++; $display("FAIL lw_ext got=%b exp=00", ext_mode); end
    tick();
    n_checks++; if (ctl_vec !== V_LW) begin n_fail++; $display("FAIL lw_ctl got=%b exp=%b", ctl_vec, V_LW); end
    set_in(I_BEQ, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    n_checks++; if (ctl_vec !== V_BEQ) begin n_fail++; $display("FAIL beq_ctl got=%b exp=%b", ctl_vec, V_BEQ); end
  endtask

  task automatic test_async_reset_in_stall;
    set_in(I_ADD, 1'b1, 1'b1, 5'd8, 1'b0);
    tick();
    n_checks++; if (stall_count !== 16'd4) begin n_fail++; $display("FAIL pre_rst_cnt got=%0d exp=4", stall_count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (stall_count !== 16'd0 || s_stall_count !== 2'd0) begin n_fail++; $display("FAIL async_cnt got=%0d/%0d exp=0/0", stall_count, s_stall_count); end
    n_checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin n_fail++; $display("FAIL async_write got=%b%b exp=11", pc_write, if_id_write); end
    rst_n = 1'b1;
    #1;
    // stall aborted: state is RUN again, so the held hazard stalls immediately
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL abort_stall got=%b exp=0", pc_write); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (s_stall_count !== 2'd3 || stall_count !== 16'd3) begin n_fail++; $display("FAIL sat_reach got=%0d/%0d exp=3/3", s_stall_count, stall_count); end
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (s_stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_hold got=%0d exp=3", s_stall_count); end
    n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL wide_cnt got=%0d exp=5", stall_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if_id_instr = 32'h0; if_id_valid = 1'b0; id_ex_mem_read = 1'b0;
    id_ex_rt = 5'd0; ex_branch_taken = 1'b0;
    test_reset();
    test_decode_andi();
    test_load_use_stall();
    test_no_hazard();
    test_sw_rt_hazard();
    test_branch_priority();
    test_illegal_and_ext();
    test_async_reset_in_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
